ring_node: RTL and testbench



---
 rtl/ring_node_if.sv | 31 +++
 rtl/ring_node.sv | 149 ++++++++++++++
 tb/tb_ring_node.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ring_node_if.sv
// Ring node bus: upstream/downstream slot, per-device grant/drive/contents and slot meter.
// slave is the node's view, master the attached environment's view.
interface ring_node_if #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned TSIZE = 4,
  parameter int unsigned SSIZE = 4
);
  logic [TSIZE-1:0]      slot_type_in;
  logic [SSIZE-1:0]      slot_source_in;
  logic [31:0]           slot_data_in;
  logic [TSIZE-1:0]      slot_type_out;
  logic [SSIZE-1:0]      slot_source_out;
  logic [31:0]           slot_data_out;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       drive;
  logic [NREQ*TSIZE-1:0] dev_type;
  logic [NREQ*32-1:0]    dev_data;
  logic [TSIZE-1:0]      meter_sel;
  logic [31:0]           meter_count;

  modport slave (
    input  slot_type_in, slot_source_in, slot_data_in, req, drive, dev_type, dev_data, meter_sel,
    output slot_type_out, slot_source_out, slot_data_out, ack, meter_count
  );

  modport master (
    output slot_type_in, slot_source_in, slot_data_in, req, drive, dev_type, dev_data, meter_sel,
    input  slot_type_out, slot_source_out, slot_data_out, ack, meter_count
  );
endinterface

// File: rtl/ring_node.sv
// Token-ring slot node: round-robin token holder with combinational slot pass/drive/nullify.
// Optional per-slot-type traffic meters are enabled by defining RING_NODE_METER_EN.
module ring_node #(
  parameter int unsigned NODENUM    = 1,
  parameter int unsigned NREQ       = 2,
  parameter int unsigned TSIZE      = 4,
  parameter int unsigned SSIZE      = 4,
  parameter int unsigned MAXHOLD    = 4,
  parameter int unsigned TOKEN_CODE = 1,
  parameter int unsigned NULL_CODE  = 0
) (
  input logic       clk,
  input logic       reset,
  ring_node_if.slave rn
);
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned HW = (MAXHOLD > 1) ? $clog2(MAXHOLD + 1) : 1;

  localparam logic [TSIZE-1:0] TokenT   = TSIZE'(TOKEN_CODE);
  localparam logic [TSIZE-1:0] NullT    = TSIZE'(NULL_CODE);
  localparam logic [SSIZE-1:0] NodeS    = SSIZE'(NODENUM);
  localparam logic [HW-1:0]    MaxHoldW = HW'(MAXHOLD);

  typedef enum logic [1:0] {StIdle, StHold, StRelease} state_e;

  state_e            state_q;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d, gnt_idx, drv_idx, cand;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic              can_xmit, gnt_found, drv_any, emit_token, hold_done;
  logic [NREQ-1:0]   ack;
  logic [TSIZE-1:0]  type_out;
  logic [SSIZE-1:0]  src_out;
  logic [31:0]       data_out;
  logic [TSIZE-1:0]  dev_type_a [NREQ];
  logic [31:0]       dev_data_a [NREQ];

  for (genvar g = 0; g < int'(NREQ); g++) begin : g_unpack
    assign dev_type_a[g] = rn.dev_type[g*TSIZE +: TSIZE];
    assign dev_data_a[g] = rn.dev_data[g*32 +: 32];
  end

  assign can_xmit = reset && (|rn.req) &&
                    ((state_q == StIdle && rn.slot_type_in == TokenT) || state_q == StHold);

  // First requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    gnt_idx   = '0;
    gnt_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      cand = PW'((int'(rr_ptr_q) + k) % int'(NREQ));
      if (!gnt_found && rn.req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    ack = '0;
    if (can_xmit) ack[gnt_idx] = 1'b1;
  end

  assign rr_ptr_d   = PW'((int'(gnt_idx) + 1) % int'(NREQ));
  assign hold_cnt_d = (state_q == StIdle) ? HW'(1) : hold_cnt_q + HW'(1);
  assign hold_done  = (MAXHOLD != 0) && (hold_cnt_d == MaxHoldW);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
    end else begin
      if (can_xmit) begin
        rr_ptr_q   <= rr_ptr_d;
        hold_cnt_q <= hold_cnt_d;
      end
      case (state_q)
        StIdle:    if (can_xmit) state_q <= hold_done ? StRelease : StHold;
        StHold: begin
          if (!can_xmit)     state_q <= StIdle;
          else if (hold_done) state_q <= StRelease;
        end
        StRelease: state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

  // Lowest-index drive wins.
  always_comb begin
    drv_any = 1'b0;
    drv_idx = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (rn.drive[PW'(i)]) begin
        drv_any = 1'b1;
        drv_idx = PW'(i);
      end
    end
  end

  assign emit_token = (state_q == StHold && !(|rn.req)) || state_q == StRelease;

  always_comb begin
    type_out = rn.slot_type_in;
    src_out  = rn.slot_source_in;
    data_out = rn.slot_data_in;
    if (!reset) begin
      type_out = NullT;
      src_out  = '0;
      data_out = '0;
    end else if (drv_any) begin
      type_out = dev_type_a[drv_idx];
      data_out = dev_data_a[drv_idx];
      src_out  = ack[drv_idx] ? NodeS : rn.slot_source_in;
    end else if (emit_token) begin
      type_out = TokenT;
      src_out  = '0;
      data_out = '0;
    end else if (rn.slot_source_in == NodeS) begin
      // Our own slot came all the way round: retire it.
      type_out = NullT;
      src_out  = '0;
      data_out = '0;
    end
  end

  assign rn.ack             = ack;
  assign rn.slot_type_out   = type_out;
  assign rn.slot_source_out = src_out;
  assign rn.slot_data_out   = data_out;

`ifdef RING_NODE_METER_EN
  localparam int unsigned NTypes = 2**TSIZE;
  logic [31:0] meter_q [NTypes];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int t = 0; t < int'(NTypes); t++) meter_q[t] <= '0;
    end else begin
      meter_q[rn.slot_type_in] <= meter_q[rn.slot_type_in] + 32'd1;
    end
  end

  assign rn.meter_count = meter_q[rn.meter_sel];
`else
  assign rn.meter_count = '0;
`endif
endmodule

// File: tb/tb_ring_node.sv
// Bench for ring_node: directed vector table, multi-cycle token sequences and randomized
// traffic checked against an abstract token-holding model (MAXHOLD=4 and MAXHOLD=0 instances).
module tb_ring_node;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  stype, ssrc, msel;
  logic [31:0] sdata;
  logic [1:0]  req, drv4, drv0;
  logic [7:0]  dtype;
  logic [63:0] ddata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ring_node_if #(.NREQ(2), .TSIZE(4), .SSIZE(4)) if4 ();
  ring_node_if #(.NREQ(2), .TSIZE(4), .SSIZE(4)) if0 ();

  assign if4.slot_type_in   = stype;
  assign if4.slot_source_in = ssrc;
  assign if4.slot_data_in   = sdata;
  assign if4.req            = req;
  assign if4.drive          = drv4;
  assign if4.dev_type       = dtype;
  assign if4.dev_data       = ddata;
  assign if4.meter_sel      = msel;
  assign if0.slot_type_in   = stype;
  assign if0.slot_source_in = ssrc;
  assign if0.slot_data_in   = sdata;
  assign if0.req            = req;
  assign if0.drive          = drv0;
  assign if0.dev_type       = dtype;
  assign if0.dev_data       = ddata;
  assign if0.meter_sel      = msel;

  ring_node #(.NODENUM(1), .NREQ(2), .TSIZE(4), .SSIZE(4), .MAXHOLD(4), .TOKEN_CODE(1),
              .NULL_CODE(0)) u_dut4 (.clk(clk), .reset(rst), .rn(if4));
  ring_node #(.NODENUM(1), .NREQ(2), .TSIZE(4), .SSIZE(4), .MAXHOLD(0), .TOKEN_CODE(1),
              .NULL_CODE(0)) u_dut0 (.clk(clk), .reset(rst), .rn(if0));

  // Model: mode 0 = no token, 1 = holding, 2 = owes the ring a token this cycle.
  typedef struct { int mode; int ptr; int grants; } mst_t;
  mst_t        m4, m0;
  logic [31:0] mcnt [16];

  typedef struct {
    logic rst; logic [3:0] t; logic [3:0] s; logic [31:0] d; logic [1:0] req; logic [1:0] drv;
    logic [1:0] eack; logic [3:0] et; logic [3:0] es; logic [31:0] ed;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] m_ack(input mst_t s);
    if (!rst) return 2'b00;
    if ((s.mode == 0 && stype == 4'd1 && req != 0) || (s.mode == 1 && req != 0)) begin
      for (int k = 0; k < 2; k++) begin
        int idx = (s.ptr + k) % 2;
        if (req[idx]) return 2'(1 << idx);
      end
    end
    return 2'b00;
  endfunction

  function automatic void m_out(input mst_t s, input logic [1:0] drv, output logic [3:0] t,
                                output logic [3:0] src, output logic [31:0] d);
    int di = -1;
    logic [1:0] a = m_ack(s);
    for (int i = 1; i >= 0; i--) if (drv[i]) di = i;
    t = stype; src = ssrc; d = sdata;
    if (!rst) begin
      t = 4'd0; src = 4'd0; d = 32'd0;
    end else if (di >= 0) begin
      t = dtype[di*4 +: 4];
      d = ddata[di*32 +: 32];
      src = a[di] ? 4'd1 : ssrc;
    end else if ((s.mode == 1 && req == 0) || s.mode == 2) begin
      t = 4'd1; src = 4'd0; d = 32'd0;
    end else if (ssrc == 4'd1) begin
      t = 4'd0; src = 4'd0; d = 32'd0;
    end
  endfunction

  function automatic mst_t m_next(input mst_t s, input int mh);
    mst_t n = s;
    logic [1:0] a = m_ack(s);
    if (!rst) begin
      n.mode = 0; n.ptr = 0; n.grants = 0;
    end else if (a != 0) begin
      n.ptr    = (a[1] ? 2 : 1) % 2;
      n.grants = (s.mode == 0 ? 0 : s.grants) + 1;
      n.mode   = (mh != 0 && n.grants == mh) ? 2 : 1;
    end else if (s.mode != 0) begin
      n.mode = 0;
    end
    return n;
  endfunction

  task automatic cmp_inst(input string tag, input mst_t s, input logic [1:0] drv,
                          input logic [1:0] a, input logic [3:0] t, input logic [3:0] src,
                          input logic [31:0] d, input logic [31:0] m);
    logic [3:0]  et, es;
    logic [31:0] ed, em;
    m_out(s, drv, et, es, ed);
`ifdef RING_NODE_METER_EN
    em = mcnt[msel];
`else
    em = 32'd0;
`endif
    chk({tag, ".ack"}, a, m_ack(s));
    chk({tag, ".type"}, t, et);
    chk({tag, ".src"}, src, es);
    chk({tag, ".data"}, d, ed);
    chk({tag, ".meter"}, m, em);
  endtask

  task automatic tick_start(input bit follow);
    if (follow) begin
      drv4 = m_ack(m4);
      drv0 = m_ack(m0);
    end
    @(negedge clk);
  endtask

  task automatic tick_end();
    cmp_inst("m4", m4, drv4, if4.ack, if4.slot_type_out, if4.slot_source_out,
             if4.slot_data_out, if4.meter_count);
    cmp_inst("m0", m0, drv0, if0.ack, if0.slot_type_out, if0.slot_source_out,
             if0.slot_data_out, if0.meter_count);
    m4 = m_next(m4, 4);
    m0 = m_next(m0, 0);
    if (!rst) for (int i = 0; i < 16; i++) mcnt[i] = 32'd0;
    else mcnt[stype] = mcnt[stype] + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input bit follow);
    tick_start(follow);
    tick_end();
  endtask

  task automatic chk_out(input string name, input logic [1:0] a, input logic [3:0] t,
                         input logic [3:0] s, input logic [31:0] d);
    chk({name, ".ack"}, if4.ack, a);
    chk({name, ".type"}, if4.slot_type_out, t);
    chk({name, ".src"}, if4.slot_source_out, s);
    chk({name, ".data"}, if4.slot_data_out, d);
  endtask

  logic [1:0] seq_ack [6];

  initial begin
    rst = 1'b0; stype = '0; ssrc = '0; sdata = '0; req = '0; drv4 = '0; drv0 = '0; msel = '0;
    dtype = 8'h97;
    ddata = {32'hBEEF_0001, 32'hDEAD_0000};
    m4 = '{0, 0, 0};
    m0 = '{0, 0, 0};
    for (int i = 0; i < 16; i++) mcnt[i] = 32'd0;
    seq_ack = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};

    //         rst  t     s     d               req    drv    eack   et    es    ed
    tbl[0] = '{1'b1, 4'd5, 4'd3, 32'hAAAA_0001, 2'b00, 2'b00, 2'b00, 4'd5, 4'd3, 32'hAAAA_0001};
    tbl[1] = '{1'b1, 4'd5, 4'd1, 32'h0000_1234, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 32'h0};
    tbl[2] = '{1'b1, 4'd5, 4'd1, 32'h0000_1234, 2'b00, 2'b01, 2'b00, 4'd7, 4'd1, 32'hDEAD_0000};
    tbl[3] = '{1'b1, 4'd5, 4'd3, 32'h0000_1234, 2'b00, 2'b11, 2'b00, 4'd7, 4'd3, 32'hDEAD_0000};
    tbl[4] = '{1'b1, 4'd5, 4'd6, 32'h0000_1234, 2'b00, 2'b10, 2'b00, 4'd9, 4'd6, 32'hBEEF_0001};
    tbl[5] = '{1'b1, 4'd2, 4'd3, 32'h0000_0042, 2'b11, 2'b00, 2'b00, 4'd2, 4'd3, 32'h42};
    tbl[6] = '{1'b1, 4'd1, 4'd0, 32'h0000_0055, 2'b00, 2'b00, 2'b00, 4'd1, 4'd0, 32'h55};
    tbl[7] = '{1'b0, 4'd1, 4'd1, 32'h0000_0066, 2'b11, 2'b01, 2'b00, 4'd0, 4'd0, 32'h0};

    tick(0);
    tick(0);

    for (int i = 0; i < 8; i++) begin
      rst = tbl[i].rst; stype = tbl[i].t; ssrc = tbl[i].s; sdata = tbl[i].d;
      req = tbl[i].req; drv4 = tbl[i].drv; drv0 = tbl[i].drv;
      tick_start(0);
      chk_out($sformatf("vec%0d", i), tbl[i].eack, tbl[i].et, tbl[i].es, tbl[i].ed);
      tick_end();
    end

    // Both requesters, MAXHOLD=4: four alternating grants, then one TOKEN slot, then idle.
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      stype = (c == 0) ? 4'd1 : 4'd5;
      ssrc  = (c == 0) ? 4'd0 : 4'd2;
      sdata = (c == 0) ? 32'd0 : 32'h77;
      req   = 2'b11;
      tick_start(1);
      if (c < 4)
        chk_out($sformatf("hold4_c%0d", c), seq_ack[c], seq_ack[c][0] ? 4'd7 : 4'd9, 4'd1,
                seq_ack[c][0] ? 32'hDEAD_0000 : 32'hBEEF_0001);
      else if (c == 4) chk_out("hold4_release", 2'b00, 4'd1, 4'd0, 32'd0);
      else chk_out("hold4_idle", 2'b00, 4'd5, 4'd2, 32'h77);
      tick_end();
    end
    req = 2'b00;
    tick(1);

    // Single grant to requester 1, then TOKEN emitted as requests stop.
    stype = 4'd1; ssrc = 4'd0; sdata = 32'd0; req = 2'b10;
    tick_start(1);
    chk_out("single_grant", 2'b10, 4'd9, 4'd1, 32'hBEEF_0001);
    tick_end();
    stype = 4'd5; ssrc = 4'd2; sdata = 32'h77; req = 2'b00;
    tick_start(1);
    chk_out("single_token", 2'b00, 4'd1, 4'd0, 32'd0);
    tick_end();
    req = 2'b11;
    tick_start(1);
    chk_out("single_idle", 2'b00, 4'd5, 4'd2, 32'h77);
    tick_end();

    // Unlimited hold: ten consecutive grants, no TOKEN until the request drops.
    for (int c = 0; c < 10; c++) begin
      stype = (c == 0) ? 4'd1 : 4'd5;
      req   = 2'b01;
      tick_start(1);
      chk($sformatf("unl_c%0d.ack", c), if0.ack, 2'b01);
      chk($sformatf("unl_c%0d.type", c), if0.slot_type_out, 4'd7);
      tick_end();
    end
    req = 2'b00;
    tick_start(1);
    chk("unl_drop.type", if0.slot_type_out, 4'd1);
    tick_end();

    // Reset while holding drops the token silently.
    stype = 4'd1; ssrc = 4'd0; req = 2'b01;
    tick(1);
    rst = 1'b0;
    tick_start(1);
    chk_out("rst_hold", 2'b00, 4'd0, 4'd0, 32'd0);
    tick_end();
    rst = 1'b1; stype = 4'd5; ssrc = 4'd2; sdata = 32'h77;
    tick_start(1);
    chk_out("rst_after", 2'b00, 4'd5, 4'd2, 32'h77);
    chk("rst_after.m0type", if0.slot_type_out, 4'd5);
    tick_end();

    // Meter: seven cycles of type 3 after a reset.
    rst = 1'b0; req = 2'b00; drv4 = '0; drv0 = '0;
    tick(0);
    rst = 1'b1; stype = 4'd3; ssrc = 4'd0;
    for (int c = 0; c < 7; c++) tick(0);
    stype = 4'd5; msel = 4'd3;
    tick_start(0);
`ifdef RING_NODE_METER_EN
    chk("meter3", if4.meter_count, 32'd7);
`else
    chk("meter3", if4.meter_count, 32'd0);
`endif
    tick_end();

    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom_range(0, 24) != 0);
      stype = ($urandom_range(0, 2) == 0) ? 4'd1 : 4'($urandom_range(0, 15));
      ssrc  = 4'($urandom_range(0, 3));
      sdata = $urandom;
      req   = 2'($urandom);
      dtype = 8'($urandom);
      ddata = {$urandom, $urandom};
      msel  = 4'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        tick(1);
      end else begin
        drv4 = 2'($urandom);
        drv0 = 2'($urandom);
        tick(0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
